conv_window_scheduler: RTL and testbench

- Sequences a K_SIZE x K_SIZE kernel window across an IMG_SIZE x IMG_SIZE input feature map.
- Per element, emits kernel indices (k_i, k_j), output position (out_row, out_col) and the input pixel coordinates the MAC datapath reads.
- Sits between the layer controller (start/done) and the MAC/accumulator.
- Raises first/last flags so the accumulator knows when to clear and when to commit each output pixel.

---
 rtl/conv_window_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
// Walks a K_SIZE x K_SIZE kernel window over an IMG_SIZE x IMG_SIZE feature map
// with the given STRIDE. Each element carries kernel indices, output pixel
// position and input pixel coordinates, with first/last flags for the
// accumulator. Elements advance only on a valid && ready handshake.
// Optional feature: define CONV_SCHED_ABORT_EN to add an 'abort' input that
// cancels a running scan without a done pulse.
module conv_window_scheduler #(
    parameter int IMG_SIZE  = 8,
    parameter int K_SIZE    = 3,
    parameter int STRIDE    = 1,
    parameter int WIDTH_BIT = 8
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 ready,
`ifdef CONV_SCHED_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 valid,
    output logic [WIDTH_BIT-1:0] k_i,
    output logic [WIDTH_BIT-1:0] k_j,
    output logic [WIDTH_BIT-1:0] out_row,
    output logic [WIDTH_BIT-1:0] out_col,
    output logic [WIDTH_BIT-1:0] img_row,
    output logic [WIDTH_BIT-1:0] img_col,
    output logic                 first,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);

    localparam int OUT_SIZE = (IMG_SIZE - K_SIZE) / STRIDE + 1;

    localparam logic [WIDTH_BIT-1:0] ZERO_W   = WIDTH_BIT'(0);
    localparam logic [WIDTH_BIT-1:0] ONE_W    = WIDTH_BIT'(1);
    localparam logic [WIDTH_BIT-1:0] K_LAST   = WIDTH_BIT'(K_SIZE - 1);
    localparam logic [WIDTH_BIT-1:0] O_LAST   = WIDTH_BIT'(OUT_SIZE - 1);
    localparam logic [WIDTH_BIT-1:0] STRIDE_W = WIDTH_BIT'(STRIDE);

    // Parameter sanity: the window must tile exactly and coordinates must fit.
    generate
        if ((IMG_SIZE - K_SIZE) % STRIDE != 0) begin : g_bad_stride
            $error("conv_window_scheduler: (IMG_SIZE-K_SIZE) must be a multiple of STRIDE");
        end
        if (IMG_SIZE >= (1 << WIDTH_BIT)) begin : g_bad_width
            $error("conv_window_scheduler: IMG_SIZE does not fit in WIDTH_BIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [WIDTH_BIT-1:0]   kj_r, ki_r, ocol_r, orow_r;
    logic [WIDTH_BIT-1:0]   kj_s, ki_s, ocol_s, orow_s;
    logic                   abort_s;
    logic                   accept_s;
    logic                   kj_wrap_s, ki_wrap_s, ocol_wrap_s, orow_last_s;
    logic                   final_s;

`ifdef CONV_SCHED_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign accept_s    = (state_r == ST_RUN) && ready;
    assign kj_wrap_s   = (kj_r == K_LAST);
    assign ki_wrap_s   = (ki_r == K_LAST);
    assign ocol_wrap_s = (ocol_r == O_LAST);
    assign orow_last_s = (orow_r == O_LAST);
    assign final_s     = accept_s && kj_wrap_s && ki_wrap_s && ocol_wrap_s && orow_last_s;

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: abort outranks the final accept; FINISH lasts one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (final_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Next counter values: nested wrap k_j -> k_i -> out_col -> out_row on accept.
    always_comb begin
        kj_s   = kj_r;
        ki_s   = ki_r;
        ocol_s = ocol_r;
        orow_s = orow_r;
        if ((state_r != ST_RUN) || abort_s || final_s) begin
            kj_s   = ZERO_W;
            ki_s   = ZERO_W;
            ocol_s = ZERO_W;
            orow_s = ZERO_W;
        end else if (accept_s) begin
            if (!kj_wrap_s) begin
                kj_s = kj_r + ONE_W;
            end else begin
                kj_s = ZERO_W;
                if (!ki_wrap_s) begin
                    ki_s = ki_r + ONE_W;
                end else begin
                    ki_s = ZERO_W;
                    if (!ocol_wrap_s) begin
                        ocol_s = ocol_r + ONE_W;
                    end else begin
                        ocol_s = ZERO_W;
                        orow_s = orow_r + ONE_W;
                    end
                end
            end
        end else begin
            kj_s   = kj_r;
            ki_s   = ki_r;
            ocol_s = ocol_r;
            orow_s = orow_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            kj_r   <= ZERO_W;
            ki_r   <= ZERO_W;
            ocol_r <= ZERO_W;
            orow_r <= ZERO_W;
        end else begin
            kj_r   <= kj_s;
            ki_r   <= ki_s;
            ocol_r <= ocol_s;
            orow_r <= orow_s;
        end
    end

    // Outputs decoded purely from registered state and counters (no ready path).
    always_comb begin
        valid   = (state_r == ST_RUN);
        busy    = (state_r == ST_RUN);
        done    = (state_r == ST_FINISH);
        k_i     = ki_r;
        k_j     = kj_r;
        out_row = orow_r;
        out_col = ocol_r;
        img_row = orow_r * STRIDE_W + ki_r;
        img_col = ocol_r * STRIDE_W + kj_r;
        first   = (state_r == ST_RUN) && (ki_r == ZERO_W) && (kj_r == ZERO_W);
        last    = (state_r == ST_RUN) && ki_wrap_s && kj_wrap_s;
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Testbench for conv_window_scheduler: a 4x4/k3/s1 instance checked against an
// arithmetic reference model under several ready patterns and corner cases,
// plus a 5x5/k3/s2 instance checked against a table of expected elements.
module tb_conv_window_scheduler;

    localparam int W  = 8;
    localparam int NB = 36;

    logic clock;
    logic nreset;

    logic start_a, ready_a, abort_a;
    logic valid_a, first_a, last_a, busy_a, done_a;
    logic [W-1:0] ki_a, kj_a, orow_a, ocol_a, irow_a, icol_a;

    logic start_b, ready_b, abort_b;
    logic valid_b, first_b, last_b, busy_b, done_b;
    logic [W-1:0] ki_b, kj_b, orow_b, ocol_b, irow_b, icol_b;

    int checks;
    int errors;

    conv_window_scheduler #(.IMG_SIZE(4), .K_SIZE(3), .STRIDE(1), .WIDTH_BIT(W)) dut_a (
        .clock(clock), .nreset(nreset), .start(start_a), .ready(ready_a),
`ifdef CONV_SCHED_ABORT_EN
        .abort(abort_a),
`endif
        .valid(valid_a), .k_i(ki_a), .k_j(kj_a), .out_row(orow_a), .out_col(ocol_a),
        .img_row(irow_a), .img_col(icol_a), .first(first_a), .last(last_a),
        .busy(busy_a), .done(done_a)
    );

    conv_window_scheduler #(.IMG_SIZE(5), .K_SIZE(3), .STRIDE(2), .WIDTH_BIT(W)) dut_b (
        .clock(clock), .nreset(nreset), .start(start_b), .ready(ready_b),
`ifdef CONV_SCHED_ABORT_EN
        .abort(abort_b),
`endif
        .valid(valid_b), .k_i(ki_b), .k_j(kj_b), .out_row(orow_b), .out_col(ocol_b),
        .img_row(irow_b), .img_col(icol_b), .first(first_b), .last(last_b),
        .busy(busy_b), .done(done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: element number -> window coordinates, by plain arithmetic.
    task automatic model(input int beat, input int img, input int k, input int s,
                         output int ki, output int kj, output int orow, output int ocol,
                         output int ir, output int ic);
        int osz, per, pix, kk;
        osz  = (img - k) / s + 1;
        per  = k * k;
        pix  = beat / per;
        kk   = beat % per;
        ki   = kk / k;
        kj   = kk % k;
        orow = pix / osz;
        ocol = pix % osz;
        ir   = orow * s + ki;
        ic   = ocol * s + kj;
    endtask

    task automatic check_a_beat(input int beat);
        int ki, kj, orow, ocol, ir, ic;
        model(beat, 4, 3, 1, ki, kj, orow, ocol, ir, ic);
        chk("a_valid", valid_a, 1);
        chk("a_busy", busy_a, 1);
        chk("a_done_in_run", done_a, 0);
        chk("a_k_i", ki_a, ki);
        chk("a_k_j", kj_a, kj);
        chk("a_out_row", orow_a, orow);
        chk("a_out_col", ocol_a, ocol);
        chk("a_img_row", irow_a, ir);
        chk("a_img_col", icol_a, ic);
        chk("a_first", first_a, (ki == 0 && kj == 0) ? 1 : 0);
        chk("a_last", last_a, (ki == 2 && kj == 2) ? 1 : 0);
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_first"}, first_a, 0);
        chk({tag, "_last"}, last_a, 0);
        chk({tag, "_k_i"}, ki_a, 0);
        chk({tag, "_k_j"}, kj_a, 0);
        chk({tag, "_out_row"}, orow_a, 0);
        chk({tag, "_out_col"}, ocol_a, 0);
    endtask

    // mode 0: ready=1, mode 1: ready 1,0,0,1 repeating, mode 2: random ready.
    task automatic scan_a(input int mode, input bit inj_start, input int rst_beat,
                          input int abort_beat);
        int beat;
        int c;
        bit fin;
        @(negedge clock);
        chk("a_idle_before_start", valid_a, 0);
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        beat = 0;
        c = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (beat == NB) begin
                chk("a_finish_done", done_a, 1);
                chk("a_finish_valid", valid_a, 0);
                chk("a_finish_busy", busy_a, 0);
                start_a = inj_start;
                fin = 1'b1;
            end else begin
                check_a_beat(beat);
                if (beat == rst_beat) begin
                    #2 nreset = 1'b0;
                    #1 check_a_zero("a_async_rst");
                    repeat (2) begin
                        @(negedge clock);
                        check_a_zero("a_in_rst");
                    end
                    nreset = 1'b1;
                    return;
                end
`ifdef CONV_SCHED_ABORT_EN
                if (beat == abort_beat) begin
                    abort_a = 1'b1;
                    ready_a = 1'b1;
                    @(negedge clock);
                    abort_a = 1'b0;
                    check_a_zero("a_abort");
                    @(negedge clock);
                    check_a_zero("a_after_abort");
                    return;
                end
`endif
                case (mode)
                    0:       ready_a = 1'b1;
                    1:       ready_a = ((c % 4) == 0) || ((c % 4) == 3);
                    default: ready_a = 1'($urandom_range(0, 1));
                endcase
                start_a = inj_start && (beat == 5);
                if (ready_a) beat++;
                c++;
            end
        end
        if (!fin) chk("a_scan_timeout", 0, 1);
        @(negedge clock);
        start_a = 1'b0;
        chk("a_idle_valid", valid_a, 0);
        chk("a_idle_busy", busy_a, 0);
        chk("a_done_one_cycle", done_a, 0);
        @(negedge clock);
        chk("a_idle_stays", valid_a, 0);
    endtask

    typedef struct {
        int beat;
        int ki, kj, orow, ocol, ir, ic, first, last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        checks  = 0;
        errors  = 0;
        tbl[0] = '{0,  0, 0, 0, 0, 0, 0, 1, 0};
        tbl[1] = '{8,  2, 2, 0, 0, 2, 2, 0, 1};
        tbl[2] = '{9,  0, 0, 0, 1, 0, 2, 1, 0};
        tbl[3] = '{13, 1, 1, 0, 1, 1, 3, 0, 0};
        tbl[4] = '{18, 0, 0, 1, 0, 2, 0, 1, 0};
        tbl[5] = '{35, 2, 2, 1, 1, 4, 4, 0, 1};

        nreset  = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; ready_b = 1'b0; abort_b = 1'b0;
        #12;
        check_a_zero("a_reset");
        chk("b_reset_valid", valid_b, 0);
        chk("b_reset_done", done_b, 0);
        @(negedge clock);
        nreset = 1'b1;

        scan_a(0, 1'b0, -1, -1);   // basic scan
        scan_a(1, 1'b0, -1, -1);   // 1,0,0,1 backpressure
        scan_a(0, 1'b1, -1, -1);   // start while busy and during FINISH
        scan_a(2, 1'b0, -1, -1);   // random ready
        scan_a(2, 1'b1, -1, -1);
        scan_a(0, 1'b0, 20, -1);   // reset mid-scan
        scan_a(0, 1'b0, -1, -1);   // clean restart after reset
`ifdef CONV_SCHED_ABORT_EN
        scan_a(0, 1'b0, -1, 12);   // abort mid-scan
        scan_a(0, 1'b0, -1, -1);
`endif

        // Strided instance: table spot checks plus model on every element.
        @(negedge clock);
        start_b = 1'b1;
        ready_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        for (int beat = 0; beat < NB; beat++) begin
            int ki, kj, orow, ocol, ir, ic;
            if (beat > 0) @(negedge clock);
            chk("b_valid", valid_b, 1);
            chk("b_busy", busy_b, 1);
            model(beat, 5, 3, 2, ki, kj, orow, ocol, ir, ic);
            chk("b_model_img_row", irow_b, ir);
            chk("b_model_img_col", icol_b, ic);
            chk("b_model_out_col", ocol_b, ocol);
            for (int t = 0; t < 6; t++) begin
                if (tbl[t].beat == beat) begin
                    chk("b_tbl_k_i", ki_b, tbl[t].ki);
                    chk("b_tbl_k_j", kj_b, tbl[t].kj);
                    chk("b_tbl_out_row", orow_b, tbl[t].orow);
                    chk("b_tbl_out_col", ocol_b, tbl[t].ocol);
                    chk("b_tbl_img_row", irow_b, tbl[t].ir);
                    chk("b_tbl_img_col", icol_b, tbl[t].ic);
                    chk("b_tbl_first", first_b, tbl[t].first);
                    chk("b_tbl_last", last_b, tbl[t].last);
                end
            end
        end
        @(negedge clock);
        chk("b_done", done_b, 1);
        chk("b_finish_valid", valid_b, 0);
        @(negedge clock);
        chk("b_done_one_cycle", done_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
